// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and helpers for the memory responder.
// Holds the response codes, both channel state encodings and the address decode helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // Operands are widened to 64 bits so base + span never wraps at the top of the map.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/bytewise_ram.sv
// DEPTH x 32 single-clock RAM: one byte-enabled write port, one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module bytewise_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [3:0][7:0] mem_q [DEPTH];
  logic [31:0]     rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[waddr][b] <= wdata[8*b +: 8];
    end
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder backed by an internal word memory, with programmable wait
// states and SLVERR for out-of-range accesses. Read and write channels run independently.
module axi_lite_mem_responder
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    DEPTH       = 1024,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [63:0] BASE64 = 64'(BASE_ADDR);
  localparam logic [63:0] SPAN64 = 64'(DEPTH) << 2;
  localparam logic [3:0]  WAIT4  = 4'(WAIT_CYCLES);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  // Write channel state
  w_state_t               w_state_q, w_state_d;
  logic                   aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
  logic                   aw_ok_q, aw_ok_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   aw_fire, w_fire, commit;

  // Read channel state
  r_state_t               r_state_q, r_state_d;
  logic                   ar_ready_q, ar_ready_d;
  logic [IDX_W-1:0]       ar_idx_q, ar_idx_d;
  logic                   ar_ok_q, ar_ok_d;
  logic [3:0]             rcnt_q, rcnt_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   ar_fire, capture;

  logic [31:0]            ram_rdata;

  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    aw_ok_d    = aw_ok_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wcnt_d     = wcnt_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    aw_fire    = S_AXI_AWVALID && aw_ready_q;
    w_fire     = S_AXI_WVALID && w_ready_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d  = 1'b1;
          aw_ready_d = 1'b0;
          aw_idx_d   = word_idx(S_AXI_AWADDR);
          aw_ok_d    = addr_in_range(64'(S_AXI_AWADDR), BASE64, SPAN64);
        end else if (!aw_held_q) begin
          aw_ready_d = 1'b1;
        end
        if (w_fire) begin
          w_held_d  = 1'b1;
          w_ready_d = 1'b0;
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
        end else if (!w_held_q) begin
          w_ready_d = 1'b1;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          w_state_d = W_WAIT;
          wcnt_d    = WAIT4;
        end
      end
      W_WAIT: begin
        if (wcnt_q == 4'd0) begin
          // A reset landing on the commit cycle must leave memory untouched.
          commit    = !reset;
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d  = W_IDLE;
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
    aw_idx_q <= aw_idx_d;
    aw_ok_q  <= aw_ok_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    wcnt_q   <= wcnt_d;
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    ar_idx_d   = ar_idx_q;
    ar_ok_d    = ar_ok_q;
    rcnt_d     = rcnt_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    capture    = 1'b0;
    ar_fire    = S_AXI_ARVALID && ar_ready_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          ar_ready_d = 1'b0;
          ar_idx_d   = word_idx(S_AXI_ARADDR);
          ar_ok_d    = addr_in_range(64'(S_AXI_ARADDR), BASE64, SPAN64);
          rcnt_d     = WAIT4;
          r_state_d  = R_WAIT;
        end else begin
          ar_ready_d = 1'b1;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 4'd0) begin
          capture   = 1'b1;
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rresp_d   = ar_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_d  = R_IDLE;
          rvalid_d   = 1'b0;
          rresp_d    = RESP_OKAY;
          ar_ready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
    ar_idx_q <= ar_idx_d;
    ar_ok_q  <= ar_ok_d;
    rcnt_q   <= rcnt_d;
  end

  // The RAM output register only reloads on capture, so RDATA holds while RVALID waits.
  bytewise_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    ((commit && aw_ok_q) ? wstrb_q : 4'b0000),
    .waddr (aw_idx_q),
    .wdata (wdata_q),
    .re    (capture && ar_ok_q),
    .raddr (ar_idx_q),
    .rdata (ram_rdata)
  );

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = w_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = (rvalid_q && ar_ok_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: one instance with no wait states, one with three.
module tb_axi_lite_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [31:0] awaddr  [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [1:0]  bresp   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rvalid  [2];
  logic        rready  [2];

  int errors = 0;
  int checks = 0;

  axi_lite_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
                           .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWVALID(awvalid[0]), .S_AXI_AWREADY(awready[0]),
    .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]), .S_AXI_WVALID(wvalid[0]),
    .S_AXI_WREADY(wready[0]), .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]),
    .S_AXI_BREADY(bready[0]), .S_AXI_ARADDR(araddr[0]), .S_AXI_ARVALID(arvalid[0]),
    .S_AXI_ARREADY(arready[0]), .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]),
    .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready[0])
  );

  axi_lite_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
                           .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst[1]),
    .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWVALID(awvalid[1]), .S_AXI_AWREADY(awready[1]),
    .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]), .S_AXI_WVALID(wvalid[1]),
    .S_AXI_WREADY(wready[1]), .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]),
    .S_AXI_BREADY(bready[1]), .S_AXI_ARADDR(araddr[1]), .S_AXI_ARVALID(arvalid[1]),
    .S_AXI_ARREADY(arready[1]), .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]),
    .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp, output int blat);
    bit aw_done, w_done;
    int n;
    awaddr[u] = a; wdata[u] = d; wstrb[u] = s;
    awvalid[u] = 1'b1; wvalid[u] = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      if (awvalid[u] && awready[u]) aw_done = 1;
      if (wvalid[u] && wready[u]) w_done = 1;
      tick(); n++;
      if (aw_done) awvalid[u] = 1'b0;
      if (w_done) wvalid[u] = 1'b0;
    end
    check("wr_handshake", 32'(aw_done && w_done), 32'd1);
    blat = 1;
    while (!bvalid[u] && blat < 50) begin
      tick(); blat++;
    end
    resp = bresp[u];
    bready[u] = 1'b1;
    tick();
    bready[u] = 1'b0;
    check("wr_bvalid_drop", 32'(bvalid[u]), 32'd0);
  endtask

  task automatic do_read(input int u, input logic [31:0] a, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int rlat);
    int n;
    araddr[u] = a; arvalid[u] = 1'b1; n = 0;
    while (!arready[u] && n < 50) begin
      tick(); n++;
    end
    check("rd_arready_seen", 32'(arready[u]), 32'd1);
    tick();
    arvalid[u] = 1'b0;
    rlat = 1;
    while (!rvalid[u] && rlat < 50) begin
      tick(); rlat++;
    end
    data = rdata[u];
    resp = rresp[u];
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rd_rdata_hold", rdata[u], data);
      check("rd_arready_low", 32'(arready[u]), 32'd0);
      check("rd_rvalid_hold", 32'(rvalid[u]), 32'd1);
    end
    rready[u] = 1'b1;
    tick();
    rready[u] = 1'b0;
    check("rd_arready_back", 32'(arready[u]), 32'd1);
    check("rd_rvalid_drop", 32'(rvalid[u]), 32'd0);
  endtask

  logic [1:0]  resp;
  logic [31:0] data;
  int          lat;
  int          n;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; awaddr[u] = '0; awvalid[u] = 1'b0; wdata[u] = '0; wstrb[u] = '0;
      wvalid[u] = 1'b0; bready[u] = 1'b0; araddr[u] = '0; arvalid[u] = 1'b0; rready[u] = 1'b0;
    end
    repeat (3) tick();
    check("rst_awready", 32'(awready[0]), 32'd0);
    check("rst_wready", 32'(wready[0]), 32'd0);
    check("rst_arready", 32'(arready[0]), 32'd0);
    check("rst_bvalid", 32'(bvalid[0]), 32'd0);
    check("rst_rvalid", 32'(rvalid[0]), 32'd0);
    check("rst_bresp", 32'(bresp[0]), 32'd0);
    check("rst_rresp", 32'(rresp[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
    check("post_rst_awready", 32'(awready[0]), 32'd1);
    check("post_rst_wready", 32'(wready[0]), 32'd1);
    check("post_rst_arready", 32'(arready[0]), 32'd1);

    // Basic write then read, no wait states
    do_write(0, BASE + 32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
    check("basic_bresp", 32'(resp), 32'd0);
    check("basic_blat", 32'(lat), 32'd2);
    do_read(0, BASE + 32'h10, 0, data, resp, lat);
    check("basic_rdata", data, 32'hDEADBEEF);
    check("basic_rresp", 32'(resp), 32'd0);
    check("basic_rlat", 32'(lat), 32'd2);

    // W leads AW by three cycles
    wdata[0] = 32'h0BADF00D; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    check("wlead_wready_pre", 32'(wready[0]), 32'd1);
    tick();
    wvalid[0] = 1'b0;
    check("wlead_wready_drop", 32'(wready[0]), 32'd0);
    check("wlead_awready_hold", 32'(awready[0]), 32'd1);
    tick(); tick();
    check("wlead_no_bvalid", 32'(bvalid[0]), 32'd0);
    awaddr[0] = BASE + 32'h20; awvalid[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    check("wlead_awready_drop", 32'(awready[0]), 32'd0);
    n = 1;
    while (!bvalid[0] && n < 50) begin
      tick(); n++;
    end
    check("wlead_blat", 32'(n), 32'd2);
    check("wlead_bresp", 32'(bresp[0]), 32'd0);
    bready[0] = 1'b1;
    tick();
    bready[0] = 1'b0;
    check("wlead_bvalid_once", 32'(bvalid[0]), 32'd0);
    check("wlead_awready_back", 32'(awready[0]), 32'd1);
    check("wlead_wready_back", 32'(wready[0]), 32'd1);
    do_write(0, BASE + 32'h24, 32'h600DCAFE, 4'hF, resp, lat);
    check("same_cycle_bresp", 32'(resp), 32'd0);
    do_read(0, BASE + 32'h20, 0, data, resp, lat);
    check("wlead_rdata", data, 32'h0BADF00D);
    do_read(0, BASE + 32'h24, 0, data, resp, lat);
    check("same_cycle_rdata", data, 32'h600DCAFE);

    // Partial strobe keeps bytes 3 and 1
    do_write(0, BASE + 32'h30, 32'h11223344, 4'hF, resp, lat);
    do_write(0, BASE + 32'h30, 32'hAABBCCDD, 4'b0101, resp, lat);
    do_read(0, BASE + 32'h30, 0, data, resp, lat);
    check("strobe_rdata", data, 32'h11BB33DD);

    // Out-of-range: one past the end would alias word 0 if decode were wrong
    do_write(0, BASE, 32'h5A5A5A5A, 4'hF, resp, lat);
    do_write(0, BASE + 32'h40, 32'hFFFFFFFF, 4'hF, resp, lat);
    check("oor_bresp", 32'(resp), 32'd2);
    do_read(0, BASE, 0, data, resp, lat);
    check("oor_mem_unchanged", data, 32'h5A5A5A5A);
    do_read(0, BASE + 32'h40, 0, data, resp, lat);
    check("oor_rdata", data, 32'd0);
    check("oor_rresp", 32'(resp), 32'd2);
    do_read(0, BASE - 32'h4, 0, data, resp, lat);
    check("below_base_rresp", 32'(resp), 32'd2);

    // Three wait states, RREADY held off for five cycles
    do_write(1, BASE + 32'h8, 32'hCAFEF00D, 4'hF, resp, lat);
    check("wait3_bresp", 32'(resp), 32'd0);
    check("wait3_blat", 32'(lat), 32'd5);
    do_read(1, BASE + 32'h8, 5, data, resp, lat);
    check("wait3_rlat", 32'(lat), 32'd5);
    check("wait3_rdata", data, 32'hCAFEF00D);
    check("wait3_rresp", 32'(resp), 32'd0);

    // Reset while the write is still counting wait states
    awaddr[1] = BASE + 32'h8; wdata[1] = 32'h12345678; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    tick();
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    check("midrst_awready", 32'(awready[1]), 32'd0);
    check("midrst_wready", 32'(wready[1]), 32'd0);
    check("midrst_arready", 32'(arready[1]), 32'd0);
    check("midrst_bvalid", 32'(bvalid[1]), 32'd0);
    check("midrst_rvalid", 32'(rvalid[1]), 32'd0);
    rst[1] = 1'b0;
    tick();
    check("midrst_awready_up", 32'(awready[1]), 32'd1);
    check("midrst_wready_up", 32'(wready[1]), 32'd1);
    check("midrst_arready_up", 32'(arready[1]), 32'd1);
    repeat (6) tick();
    check("midrst_no_bvalid", 32'(bvalid[1]), 32'd0);
    do_read(1, BASE + 32'h8, 0, data, resp, lat);
    check("midrst_old_data", data, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
